// File: rtl/sample_tick_gen_if.sv
// Control/status bundle for sample_tick_gen.
// SAMPLE_IDX_EN adds the sample_idx status signal.
interface sample_tick_gen_if #(
    parameter int CNT_W   = 20,
    parameter int NUM_CH  = 2,
    parameter int BURST_W = 8
);
    logic                    start;
    logic                    stop;
    logic                    burst_mode;
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] phase;
    logic [BURST_W-1:0]      burst_len;
    logic [NUM_CH-1:0]       tick;
    logic                    busy;
    logic                    done;
`ifdef SAMPLE_IDX_EN
    logic [BURST_W-1:0]      sample_idx;

    modport master (
        output start, stop, burst_mode,
        output period, phase, burst_len,
        input  tick, busy, done, sample_idx
    );
    modport slave (
        input  start, stop, burst_mode,
        input  period, phase, burst_len,
        output tick, busy, done, sample_idx
    );
`else
    modport master (
        output start, stop, burst_mode,
        output period, phase, burst_len,
        input  tick, busy, done
    );
    modport slave (
        input  start, stop, burst_mode,
        input  period, phase, burst_len,
        output tick, busy, done
    );
`endif
endinterface

// File: rtl/sample_tick_gen.sv
// Multi-channel phased sample tick generator, continuous or burst.
// Define SAMPLE_IDX_EN to add the channel-0 sample index output.
module sample_tick_gen #(
    parameter int CNT_W   = 20,
    parameter int NUM_CH  = 2,
    parameter int BURST_W = 8
) (
    input  logic clk,
    input  logic rst,
    sample_tick_gen_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]   r_per;
    logic               r_bmode;
    logic [BURST_W-1:0] r_blen;
    logic [BURST_W-1:0] r_bcnt;
    logic [BURST_W-1:0] w_bnext;
    logic [CNT_W-1:0]   r_cnt  [NUM_CH];
    logic [CNT_W-1:0]   w_ph   [NUM_CH];
    logic [CNT_W-1:0]   w_load [NUM_CH];
    logic [NUM_CH-1:0]  r_tick;
    logic [NUM_CH-1:0]  w_hit;
    logic               w_go;
    logic               w_last;

    assign w_go    = bus.start & ~bus.stop;
    assign w_bnext = r_bcnt + BURST_W'(1);
    assign w_last  = r_bmode & w_hit[0]
                   & (w_bnext == r_blen);

    // Phase saturates at the period so the first tick is never late.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_ph[c]   = bus.phase[c*CNT_W +: CNT_W];
            w_load[c] = bus.period;
            if (w_ph[c] > bus.period)
                w_load[c] = '0;
            else
                w_load[c] = bus.period - w_ph[c];
            w_hit[c]  = (r_cnt[c] == r_per);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (bus.burst_mode && bus.burst_len == '0)
                        w_next = S_DONE;
                    else
                        w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop)  w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per   <= '0;
            r_bmode <= 1'b0;
            r_blen  <= '0;
            r_bcnt  <= '0;
            r_tick  <= '0;
            for (int c = 0; c < NUM_CH; c++)
                r_cnt[c] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (w_go) begin
                        r_per   <= bus.period;
                        r_bmode <= bus.burst_mode;
                        r_blen  <= bus.burst_len;
                        r_bcnt  <= '0;
                        for (int c = 0; c < NUM_CH; c++)
                            r_cnt[c] <= w_load[c];
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_tick <= '0;
                    end else begin
                        r_tick <= w_hit;
                        if (w_hit[0]) r_bcnt <= w_bnext;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (w_hit[c]) r_cnt[c] <= '0;
                            else r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                        end
                    end
                end
                default: r_tick <= '0;
            endcase
        end
    end

    assign bus.tick = r_tick;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);

`ifdef SAMPLE_IDX_EN
    logic [BURST_W-1:0] r_sidx;

    // r_bcnt counts in both modes, so it also supplies the wrapping index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sidx <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_go) r_sidx <= '0;
        end else if (r_state == S_RUN) begin
            if (!bus.stop && w_hit[0]) r_sidx <= r_bcnt;
        end
    end

    assign bus.sample_idx = r_sidx;
`endif
endmodule

// File: tb/tb_sample_tick_gen.sv
// Directed bench for sample_tick_gen.
// Records per-edge tick/busy/done masks and compares with hand-built ones.
module tb_sample_tick_gen;
    localparam int CNT_W   = 20;
    localparam int NUM_CH  = 2;
    localparam int BURST_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   sidx_bad = 0;
    logic [BURST_W-1:0] sidx_exp = '0;

    sample_tick_gen_if #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .BURST_W(BURST_W)
    ) bus ();

    sample_tick_gen #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .BURST_W(BURST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(int f, int s, int l);
        logic [63:0] m;
        m = '0;
        for (int e = f; e <= l; e += s) m[e] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic bm, input int per,
                            input int ph0, input int ph1,
                            input int len, input bit hold);
        bus.burst_mode = bm;
        bus.period     = CNT_W'(per);
        bus.phase      = {CNT_W'(ph1), CNT_W'(ph0)};
        bus.burst_len  = BURST_W'(len);
        bus.start      = 1'b1;
        sidx_exp       = '0;
        step();
        if (!hold) bus.start = 1'b0;
        // config changes after the start edge must have no effect
        bus.period    = CNT_W'(5);
        bus.phase     = '0;
        bus.burst_len = BURST_W'(1);
    endtask

    task automatic run_rec(input int n, input int stop_at,
                           output logic [63:0] t0,
                           output logic [63:0] t1,
                           output logic [63:0] bz,
                           output logic [63:0] dn);
        t0 = '0; t1 = '0; bz = '0; dn = '0;
        for (int e = 1; e <= n; e++) begin
            if (e == stop_at) bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
            t0[e] = bus.tick[0];
            t1[e] = bus.tick[1];
            bz[e] = bus.busy;
            dn[e] = bus.done;
`ifdef SAMPLE_IDX_EN
            if (bus.tick[0]) begin
                if (bus.sample_idx !== sidx_exp) sidx_bad++;
                sidx_exp++;
            end
`endif
        end
    endtask

    logic [63:0] t0, t1, bz, dn;

    initial begin
        bus.start = 0; bus.stop = 0; bus.burst_mode = 0;
        bus.period = '0; bus.phase = '0; bus.burst_len = '0;
        #12;
        chk("rst_tick", 64'(bus.tick), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        step();

        // continuous, period 4, phases {0,2}
        do_start(1'b0, 4, 0, 2, 0, 1'b0);
        run_rec(20, -1, t0, t1, bz, dn);
        chk("cont_t0", t0, mk(1, 5, 16));
        chk("cont_t1", t1, mk(3, 5, 18));
        chk("cont_busy", bz, mk(1, 1, 20));
        chk("cont_done", dn, 64'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("cont_stop_busy", 64'(bus.busy), 64'd0);
        chk("cont_stop_tick", 64'(bus.tick), 64'd0);

        // burst of 16, period 2, phases {0,1}
        do_start(1'b1, 2, 0, 1, 16, 1'b0);
        run_rec(55, -1, t0, t1, bz, dn);
        chk("bur_t0", t0, mk(1, 3, 46));
        chk("bur_t1", t1, mk(2, 3, 44));
        chk("bur_busy", bz, mk(1, 1, 45));
        chk("bur_done", dn, mk(46, 1, 46));
`ifdef SAMPLE_IDX_EN
        chk("bur_sidx_bad", 64'(sidx_bad), 64'd0);
        chk("bur_sidx_last", 64'(bus.sample_idx), 64'd15);
`endif

        // period 0, burst of 3, ch1 phase saturates
        do_start(1'b1, 0, 0, 7, 3, 1'b0);
        run_rec(8, -1, t0, t1, bz, dn);
        chk("p0_t0", t0, mk(1, 1, 3));
        chk("p0_t1", t1, mk(1, 1, 3));
        chk("p0_done", dn, mk(3, 1, 3));
        chk("p0_busy", bz, mk(1, 1, 2));

        // continuous period 3, stop at edge 10
        do_start(1'b0, 3, 0, 0, 0, 1'b0);
        run_rec(20, 10, t0, t1, bz, dn);
        chk("stop_t0", t0, mk(1, 4, 9));
        chk("stop_busy", bz, mk(1, 1, 9));
        chk("stop_done", dn, 64'd0);

        // restart with period 1, start held high during RUN
        do_start(1'b0, 1, 0, 0, 0, 1'b1);
        run_rec(10, -1, t0, t1, bz, dn);
        chk("hold_t0", t0, mk(1, 2, 9));
        chk("hold_busy", bz, mk(1, 1, 10));
        bus.stop = 1'b1;
        step();
        step();
        chk("stop_start_busy", 64'(bus.busy), 64'd0);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // async reset in the middle of a burst
        do_start(1'b1, 2, 0, 1, 16, 1'b0);
        run_rec(4, -1, t0, t1, bz, dn);
        chk("pre_rst_t0", 64'(bus.tick[0]), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_tick", 64'(bus.tick), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        #1 rst = 1'b0;
        step();

        // burst with length 0
        do_start(1'b1, 3, 0, 0, 0, 1'b0);
        chk("len0_done", 64'(bus.done), 64'd1);
        chk("len0_busy", 64'(bus.busy), 64'd0);
        chk("len0_tick", 64'(bus.tick), 64'd0);
        step();
        chk("len0_done2", 64'(bus.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
